// File: rtl/wave_gen_param.sv
// Parameterised duty-cycle waveform generator: prescaled ramp accumulator with
// triangle / saw-up / square / saw-down shaping, amplitude divider and output gate.
module wave_gen_param #(
  parameter int unsigned DW   = 7,
  parameter int unsigned PW   = 6,
  parameter int unsigned STEP = 2
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] rate,
  input  logic [2:0]    clip_factor,
  output logic [DW-1:0] duty_out,
  output logic          period_tick,
  output logic          dir_up
);

  localparam int unsigned AW = DW + 1;
  localparam logic [AW-1:0] MAX_W  = AW'((2 ** DW) - 1);
  localparam logic [AW-1:0] STEP_W = AW'(STEP);
  localparam logic [DW-1:0] MAX_D  = DW'((2 ** DW) - 1);

  localparam logic [1:0] MODE_TRI    = 2'b00;
  localparam logic [1:0] MODE_SAW_UP = 2'b01;
  localparam logic [1:0] MODE_SQUARE = 2'b10;
  localparam logic [1:0] MODE_SAW_DN = 2'b11;

  logic [PW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          dir_d;
  logic [1:0]    mode_q;
  logic          wrap;
  logic          tick;
  logic          mode_chg;
  logic [AW-1:0] acc_w, sum_w;
  logic [DW-1:0] shaped;
  logic [DW-1:0] eff_clip;
  logic [DW-1:0] duty_d;

  // Prescaler: ">=" also covers a rate lowered below the running count.
  always_comb begin
    tick     = (cnt_q >= rate);
    mode_chg = (mode != mode_q);
    cnt_d    = cnt_q + PW'(1);
    if (mode_chg || tick) begin
      cnt_d = '0;
    end
  end

  // Ramp next-state; sums carry one extra bit so acc+STEP cannot wrap.
  always_comb begin
    acc_d = acc_q;
    dir_d = dir_up;
    wrap  = 1'b0;
    acc_w = {1'b0, acc_q};
    sum_w = acc_w + STEP_W;
    if (mode_chg) begin
      if (mode == MODE_SAW_DN) begin
        acc_d = MAX_D;
        dir_d = 1'b0;
      end else begin
        acc_d = '0;
        dir_d = 1'b1;
      end
    end else begin
      case (mode_q)
        MODE_SAW_UP: begin
          dir_d = 1'b1;
          if (tick) begin
            if (sum_w > MAX_W) begin
              acc_d = '0;
              wrap  = 1'b1;
            end else begin
              acc_d = DW'(sum_w);
            end
          end
        end
        MODE_SAW_DN: begin
          dir_d = 1'b0;
          if (tick) begin
            if (acc_w < STEP_W) begin
              acc_d = MAX_D;
              wrap  = 1'b1;
            end else begin
              acc_d = DW'(acc_w - STEP_W);
            end
          end
        end
        default: begin
          if (tick) begin
            if (dir_up) begin
              if (sum_w >= MAX_W) begin
                acc_d = MAX_D;
                dir_d = 1'b0;
              end else begin
                acc_d = DW'(sum_w);
              end
            end else begin
              if (acc_w <= STEP_W) begin
                acc_d = '0;
                dir_d = 1'b1;
                wrap  = 1'b1;
              end else begin
                acc_d = DW'(acc_w - STEP_W);
              end
            end
          end
        end
      endcase
    end
  end

  // Output shaping and amplitude divide (clip of 0 behaves as 1).
  always_comb begin
    shaped = acc_q;
    if (mode_q == MODE_SQUARE) begin
      shaped = dir_up ? MAX_D : '0;
    end
    eff_clip = (clip_factor == 3'd0) ? DW'(1) : DW'(clip_factor);
    duty_d   = enable ? DW'(shaped / eff_clip) : '0;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      dir_up      <= 1'b1;
      mode_q      <= mode;
      duty_out    <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dir_up      <= dir_d;
      mode_q      <= mode;
      duty_out    <= duty_d;
      period_tick <= wrap;
    end
  end

  wire unused_tri = (MODE_TRI == 2'b00);

endmodule
